// File: rtl/cpu_sequencer_if.sv
// IMEM fetch bus and DMEM req/ack handshake between the sequencer and its memories.
interface cpu_sequencer_if;
    logic [7:0] ADD;
    logic [7:0] Ins;
    logic       Mem_Req;
    logic       Mem_We;
    logic       Mem_Ack;

    modport master (
        output ADD,
        output Mem_Req,
        output Mem_We,
        input  Ins,
        input  Mem_Ack
    );

    modport slave (
        input  ADD,
        input  Mem_Req,
        input  Mem_We,
        output Ins,
        output Mem_Ack
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multicycle control FSM for the 8-bit, 4-register CPU: fetch, decode, execute and retire
// with run/step control, halt/fault detection and a saturating retired-instruction counter.
module cpu_sequencer #(
    parameter int unsigned IMEM_DEPTH = 26,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Run,
    input  logic             Step,
    cpu_sequencer_if.master  bus,
    output logic [1:0]       Rs_Sel,
    output logic [1:0]       Rt_Sel,
    output logic [1:0]       Wr_Sel,
    output logic             RegWrite,
    output logic             WB_Src,
    output logic [7:0]       Offset,
    output logic             Busy,
    output logic             Halted,
    output logic             Fault,
    output logic [CNT_W-1:0] InstrCount
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StFetch  = 3'd1;
    localparam logic [2:0] StDecode = 3'd2;
    localparam logic [2:0] StAlu    = 3'd3;
    localparam logic [2:0] StMem    = 3'd4;
    localparam logic [2:0] StJump   = 3'd5;
    localparam logic [2:0] StHalt   = 3'd6;

    localparam logic [1:0] OpAlu   = 2'b00;
    localparam logic [1:0] OpLoad  = 2'b01;
    localparam logic [1:0] OpStore = 2'b10;

    logic [2:0]       r_state;
    logic [7:0]       r_add;
    logic [7:0]       r_ir;
    logic [CNT_W-1:0] r_cnt;
    logic             r_halted;
    logic             r_fault;
    logic             r_step;

    logic [1:0] w_op;
    logic [7:0] w_sext;
    logic [7:0] w_pc_inc;
    logic [7:0] w_target;
    logic [7:0] w_next_pc;
    logic       w_retire;
    logic       w_self_jump;
    logic       w_oob;
    logic       w_mem_req;

    assign w_op        = r_ir[7:6];
    assign w_sext      = {{6{r_ir[1]}}, r_ir[1:0]};
    assign w_pc_inc    = r_add + 8'd1;
    assign w_target    = w_pc_inc + w_sext;
    assign w_mem_req   = (r_state == StMem);
    assign w_retire    = (r_state == StAlu) || (r_state == StJump) || (w_mem_req && bus.Mem_Ack);
    assign w_next_pc   = (r_state == StJump) ? w_target : w_pc_inc;
    assign w_self_jump = (r_state == StJump) && (w_target == r_add);
    assign w_oob       = 32'(w_next_pc) >= IMEM_DEPTH;

    // Strobes decode straight from state so an async reset drops them immediately.
    always_comb begin
        bus.ADD     = r_add;
        bus.Mem_Req = w_mem_req;
        bus.Mem_We  = w_mem_req && (w_op == OpStore);
        RegWrite    = (r_state == StAlu) || (w_mem_req && bus.Mem_Ack && (w_op == OpLoad));
        WB_Src      = w_mem_req;
        Wr_Sel      = 2'b00;
        if (RegWrite) begin
            Wr_Sel = w_mem_req ? r_ir[3:2] : r_ir[1:0];
        end
        Rs_Sel      = r_ir[5:4];
        Rt_Sel      = r_ir[3:2];
        Offset      = w_sext;
        Busy        = (r_state != StIdle) && (r_state != StHalt);
        Halted      = r_halted;
        Fault       = r_fault;
        InstrCount  = r_cnt;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= StIdle;
            r_add    <= 8'd0;
            r_ir     <= 8'd0;
            r_cnt    <= '0;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
            r_step   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (Run || Step) begin
                        r_state <= StFetch;
                        r_step  <= !Run;
                    end
                end
                StFetch: begin
                    r_ir    <= bus.Ins;
                    r_state <= StDecode;
                end
                StDecode: begin
                    case (w_op)
                        OpAlu:   r_state <= StAlu;
                        OpLoad,
                        OpStore: r_state <= StMem;
                        default: r_state <= StJump;
                    endcase
                end
                StAlu, StMem, StJump: begin
                    if (w_retire) begin
                        if (r_cnt != {CNT_W{1'b1}}) begin
                            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                        if (w_self_jump) begin
                            r_halted <= 1'b1;
                            r_state  <= StHalt;
                        end else if (w_oob) begin
                            // ADD keeps the PC of the faulting instruction.
                            r_fault  <= 1'b1;
                            r_halted <= 1'b1;
                            r_state  <= StHalt;
                        end else begin
                            r_add   <= w_next_pc;
                            r_state <= (Run && !r_step) ? StFetch : StIdle;
                        end
                    end
                end
                StHalt:  r_state <= StHalt;
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: IMEM/DMEM models plus a scoreboard of fetch
// addresses and register writes.
module tb_cpu_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Run;
    logic        Step;
    logic [1:0]  Rs_Sel, Rt_Sel, Wr_Sel;
    logic        RegWrite, WB_Src, Busy, Halted, Fault;
    logic [7:0]  Offset;
    logic [15:0] InstrCount;

    cpu_sequencer_if bus ();

    cpu_sequencer #(
        .IMEM_DEPTH (26),
        .CNT_W      (16)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Run        (Run),
        .Step       (Step),
        .bus        (bus.master),
        .Rs_Sel     (Rs_Sel),
        .Rt_Sel     (Rt_Sel),
        .Wr_Sel     (Wr_Sel),
        .RegWrite   (RegWrite),
        .WB_Src     (WB_Src),
        .Offset     (Offset),
        .Busy       (Busy),
        .Halted     (Halted),
        .Fault      (Fault),
        .InstrCount (InstrCount)
    );

    always #5 CLK = ~CLK;

    logic [7:0] imem [256];
    int         ack_delay;
    int         ack_cnt;

    assign bus.Ins     = imem[bus.ADD];
    assign bus.Mem_Ack = bus.Mem_Req && (ack_cnt >= ack_delay);

    always @(posedge CLK) begin
        if (!bus.Mem_Req || bus.Mem_Ack) ack_cnt <= 0;
        else                             ack_cnt <= ack_cnt + 1;
    end

    int         checks = 0;
    int         errors = 0;
    logic [7:0] q_add [$];
    logic [2:0] q_wr  [$];
    bit         mon_en = 1'b0;
    logic [7:0] prev_add;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every new ADD and every RegWrite pulse pops one expectation.
    initial begin
        logic [7:0] ea;
        logic [2:0] ew;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                if (bus.ADD !== prev_add) begin
                    prev_add = bus.ADD;
                    ea = (q_add.size() != 0) ? q_add.pop_front() : 8'hxx;
                    checks++;
                    assert (bus.ADD === ea) else begin
                        errors++;
                        $error("FAIL add_seq: observed %0d expected %0d", bus.ADD, ea);
                    end
                end
                if (RegWrite === 1'b1) begin
                    ew = (q_wr.size() != 0) ? q_wr.pop_front() : 3'bxxx;
                    checks++;
                    assert ({WB_Src, Wr_Sel} === ew) else begin
                        errors++;
                        $error("FAIL regwrite: observed {wb,sel}=%0h expected %0h",
                               {WB_Src, Wr_Sel}, ew);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        mon_en = 1'b0;
        RST  = 1'b1;
        Run  = 1'b0;
        Step = 1'b0;
        q_add.delete();
        q_wr.delete();
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        ack_delay = 0;
        @(posedge CLK);
        #1 RST = 1'b0;
        prev_add = 8'd0;
    endtask

    task automatic wait_halt(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge CLK);
            if (Halted === 1'b1) break;
        end
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge CLK);
            if (Busy === 1'b0) break;
        end
    endtask

    task automatic step_pulse();
        @(posedge CLK);
        #1 Step = 1'b1;
        @(posedge CLK);
        #1 Step = 1'b0;
    endtask

    // Long program: 0..19 ALU, 20 jump to 22, 22 jump back to 21, 21 jump to 23,
    // 23 ALU, 24 given by caller.
    task automatic load_long(input logic [7:0] ins24);
        for (int i = 0; i < 20; i++) begin
            imem[i] = 8'h00;
            q_wr.push_back(3'b000);
        end
        imem[20] = 8'hC1;
        imem[22] = 8'hC2;
        imem[21] = 8'hC1;
        imem[23] = 8'h00;
        q_wr.push_back(3'b000);
        imem[24] = ins24;
        for (int i = 1; i <= 20; i++) q_add.push_back(8'(i));
        q_add.push_back(8'd22);
        q_add.push_back(8'd21);
        q_add.push_back(8'd23);
        q_add.push_back(8'd24);
    endtask

    initial begin
        int req_cycles, we_seen, rw_cnt, rw_ack, rw_wb;
        logic [7:0] off_seen;

        // Reset state
        do_reset();
        chk("rst_add", bus.ADD, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_halted", Halted, 0);
        chk("rst_fault", Fault, 0);
        chk("rst_count", InstrCount, 0);
        chk("rst_strobes", {RegWrite, bus.Mem_Req}, 0);

        // Standard program under Run
        imem[0] = 8'h02; imem[1] = 8'h48; imem[2] = 8'h80; imem[3] = 8'h01;
        imem[4] = 8'hC1; imem[6] = 8'h03; imem[7] = 8'hC3;
        q_add = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd7};
        q_wr  = '{3'b010, 3'b110, 3'b001, 3'b011};
        mon_en = 1'b1;
        Run = 1'b1;
        wait_halt(100);
        chk("std_halted", Halted, 1);
        chk("std_fault", Fault, 0);
        chk("std_add", bus.ADD, 7);
        chk("std_count", InstrCount, 7);
        repeat (5) @(negedge CLK);
        chk("std_count_frozen", InstrCount, 7);
        chk("std_busy", Busy, 0);
        chk("std_q_add_empty", q_add.size(), 0);
        chk("std_q_wr_empty", q_wr.size(), 0);

        // Single-stepped load with Mem_Ack three cycles late
        do_reset();
        imem[0] = 8'h4D;
        imem[1] = 8'h02;
        ack_delay = 3;
        q_add = '{8'd1};
        q_wr  = '{3'b111};
        mon_en = 1'b1;
        req_cycles = 0; we_seen = 0; rw_cnt = 0; rw_ack = 0; rw_wb = 0; off_seen = 8'h00;
        step_pulse();
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (bus.Mem_Req === 1'b1) begin
                req_cycles++;
                if (bus.Mem_We !== 1'b0) we_seen++;
                off_seen = Offset;
            end
            if (RegWrite === 1'b1) begin
                rw_cnt++;
                if (bus.Mem_Ack === 1'b1) rw_ack++;
                if (WB_Src === 1'b1) rw_wb++;
            end
            if (Busy === 1'b0) break;
        end
        chk("ld_req_cycles", req_cycles, 4);
        chk("ld_we", we_seen, 0);
        chk("ld_offset", off_seen, 8'h01);
        chk("ld_regwrite_cnt", rw_cnt, 1);
        chk("ld_regwrite_in_ack", rw_ack, 1);
        chk("ld_wb_src", rw_wb, 1);
        chk("ld_busy", Busy, 0);
        chk("ld_count", InstrCount, 1);
        chk("ld_add", bus.ADD, 1);

        // Step with Run=0: exactly one ALU instruction, then back to IDLE
        q_add.push_back(8'd2);
        q_wr.push_back(3'b010);
        step_pulse();
        wait_idle(10);
        chk("step_count", InstrCount, 2);
        chk("step_add", bus.ADD, 2);
        repeat (4) @(negedge CLK);
        chk("step_busy", Busy, 0);
        chk("step_count_hold", InstrCount, 2);
        chk("step_q_empty", q_add.size() + q_wr.size(), 0);

        // Backward jump then self-jump halt at PC=24
        do_reset();
        load_long(8'hC3);
        mon_en = 1'b1;
        Run = 1'b1;
        wait_halt(200);
        chk("selfjmp_halted", Halted, 1);
        chk("selfjmp_fault", Fault, 0);
        chk("selfjmp_add", bus.ADD, 24);
        chk("selfjmp_count", InstrCount, 25);
        repeat (5) @(negedge CLK);
        chk("selfjmp_count_frozen", InstrCount, 25);
        chk("selfjmp_q_empty", q_add.size() + q_wr.size(), 0);

        // Jump past the end of IMEM faults
        do_reset();
        load_long(8'hC1);
        mon_en = 1'b1;
        Run = 1'b1;
        wait_halt(200);
        chk("fault_fault", Fault, 1);
        chk("fault_halted", Halted, 1);
        chk("fault_busy", Busy, 0);
        chk("fault_add", bus.ADD, 24);
        chk("fault_count", InstrCount, 25);
        chk("fault_q_empty", q_add.size() + q_wr.size(), 0);

        // Async reset while a load waits on Mem_Ack
        do_reset();
        imem[0] = 8'h00;
        imem[1] = 8'h48;
        ack_delay = 1000;
        Run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (bus.Mem_Req === 1'b1) break;
        end
        chk("arst_req_before", bus.Mem_Req, 1);
        chk("arst_add_before", bus.ADD, 1);
        chk("arst_count_before", InstrCount, 1);
        #2 RST = 1'b1;
        #1;
        chk("arst_req", bus.Mem_Req, 0);
        chk("arst_regwrite", RegWrite, 0);
        chk("arst_add", bus.ADD, 0);
        chk("arst_count", InstrCount, 0);
        chk("arst_busy", Busy, 0);
        @(posedge CLK);
        #1 RST = 1'b0;
        Run = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
